// File: rtl/debug_addr_sel.sv
// Debug address selector: rotary encoder, push button and group button
// inputs are synchronized, debounced and edge-detected to step an 8-bit {group, index} address.
module debug_addr_sel #(
  parameter int unsigned DB_CNT_W = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rot_a,
  input  logic       rot_b,
  input  logic       rot_push,
  input  logic       btn_mode,
  output logic [7:0] addr,
  output logic       addr_changed
);

  typedef enum logic [2:0] {
    GRP_REGS = 3'b000,
    GRP_DP   = 3'b001,
    GRP_CP0  = 3'b010
  } grp_t;

  // channel order: [0] rot_a, [1] rot_b, [2] rot_push, [3] btn_mode
  logic [3:0]          raw;
  logic [3:0]          sync1;
  logic [3:0]          sync2;
  logic [3:0]          deb;
  logic [3:0]          prev;
  logic [DB_CNT_W-1:0] cnt [4];

  logic step_up;
  logic step_dn;
  logic push_rise;
  logic mode_rise;

  grp_t       grp;
  logic [4:0] idx;
  logic [4:0] idx_max;

  assign raw = {btn_mode, rot_push, rot_b, rot_a};

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted once it has differed from deb for 2^DB_CNT_W cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      deb <= '0;
      for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == '1) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev      <= '0;
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      push_rise <= 1'b0;
      mode_rise <= 1'b0;
    end else begin
      prev      <= deb;
      step_up   <= deb[0] & ~prev[0] & ~deb[1];
      step_dn   <= deb[0] & ~prev[0] &  deb[1];
      push_rise <= deb[2] & ~prev[2];
      mode_rise <= deb[3] & ~prev[3];
    end
  end

  always_comb begin
    idx_max = (grp == GRP_DP) ? 5'd23 : 5'd31;
  end

  // Priority: group change, then index clear, then rotation step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grp          <= GRP_REGS;
      idx          <= '0;
      addr_changed <= 1'b0;
    end else begin
      addr_changed <= 1'b0;
      if (mode_rise) begin
        case (grp)
          GRP_REGS: grp <= GRP_DP;
          GRP_DP:   grp <= GRP_CP0;
          default:  grp <= GRP_REGS;
        endcase
        idx          <= '0;
        addr_changed <= 1'b1;
      end else if (push_rise) begin
        idx          <= '0;
        addr_changed <= 1'b1;
      end else if (step_up) begin
        idx          <= (idx >= idx_max) ? 5'd0 : idx + 5'd1;
        addr_changed <= 1'b1;
      end else if (step_dn) begin
        idx          <= (idx == 5'd0 || idx > idx_max) ? idx_max : idx - 5'd1;
        addr_changed <= 1'b1;
      end
    end
  end

  assign addr = {grp, idx};

endmodule

// File: tb/tb_debug_addr_sel.sv
// Scoreboard bench for debug_addr_sel with a 3-bit debounce counter.
module tb_debug_addr_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rot_a = 1'b0;
  logic       rot_b = 1'b0;
  logic       rot_push = 1'b0;
  logic       btn_mode = 1'b0;
  logic [7:0] addr;
  logic       addr_changed;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  logic [7:0]  sb_q[$];
  logic [7:0]  last_addr = 8'h00;

  debug_addr_sel #(.DB_CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .rot_a        (rot_a),
    .rot_b        (rot_b),
    .rot_push     (rot_push),
    .btn_mode     (btn_mode),
    .addr         (addr),
    .addr_changed (addr_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Monitor: every pulse pops one expected address; no pulse means addr must hold.
  always @(negedge clk) begin
    if (!rst) begin
      last_addr = addr;
    end else if (addr_changed) begin
      if (sb_q.size() == 0) begin
        chk("spurious_pulse", {31'd0, addr_changed}, 32'd0);
      end else begin
        chk("addr", {24'd0, addr}, {24'd0, sb_q.pop_front()});
      end
      last_addr = addr;
    end else if (addr !== last_addr) begin
      chk("addr_stable", {24'd0, addr}, {24'd0, last_addr});
      last_addr = addr;
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic drain();
    int unsigned w;
    w = 0;
    while (sb_q.size() != 0 && w < 100) begin
      tick(1);
      w++;
    end
    if (sb_q.size() != 0) begin
      chk("drain_timeout", sb_q.size(), 32'd0);
      sb_q.delete();
    end
  endtask

  task automatic step(input bit up, input logic [7:0] exp);
    if (!up) begin
      rot_b = 1'b1;
      tick(16);
    end
    sb_q.push_back(exp);
    rot_a = 1'b1;
    tick(16);
    rot_a = 1'b0;
    tick(16);
    rot_b = 1'b0;
    tick(16);
    drain();
  endtask

  task automatic press_mode(input logic [7:0] exp);
    sb_q.push_back(exp);
    btn_mode = 1'b1;
    tick(16);
    btn_mode = 1'b0;
    tick(16);
    drain();
  endtask

  task automatic press_push(input logic [7:0] exp);
    sb_q.push_back(exp);
    rot_push = 1'b1;
    tick(16);
    rot_push = 1'b0;
    tick(16);
    drain();
  endtask

  initial begin
    int unsigned lat;

    // Reset and idle
    rst = 1'b0;
    tick(5);
    rst = 1'b1;
    tick(50);
    chk("reset_addr", {24'd0, addr}, 32'h00);
    chk("reset_pulse", {31'd0, addr_changed}, 32'd0);

    // Glitch shorter than the debounce window
    rot_a = 1'b1;
    tick(5);
    rot_a = 1'b0;
    tick(30);
    chk("glitch_addr", {24'd0, addr}, 32'h00);

    // First CW step with latency measurement
    sb_q.push_back(8'h01);
    rot_a = 1'b1;
    lat = 0;
    while (addr_changed !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("latency_in_range", {31'd0, (lat >= 11 && lat <= 13)}, 32'd1);
    tick(16);
    rot_a = 1'b0;
    tick(16);
    drain();

    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    step(1'b1, 8'h04);

    // Datapath group: wrap at 23
    press_mode(8'h20);
    for (int unsigned i = 0; i < 24; i++) step(1'b1, 8'h20 | 8'((i + 1) % 24));
    chk("dp_wrap_up", {24'd0, addr}, 32'h20);
    step(1'b0, 8'h37);

    press_mode(8'h40);
    press_mode(8'h00);

    // Register group: wrap at 31 both directions
    step(1'b0, 8'h1F);
    step(1'b1, 8'h00);
    press_push(8'h00);

    // CP0 group and push clears index
    press_mode(8'h20);
    press_mode(8'h40);
    for (int unsigned i = 0; i < 5; i++) step(1'b1, 8'h40 | 8'(i + 1));
    press_push(8'h40);
    press_push(8'h40);
    chk("cp0_push", {24'd0, addr}, 32'h40);

    // Simultaneous mode + step: mode wins
    press_mode(8'h00);
    step(1'b1, 8'h01);
    step(1'b1, 8'h02);
    step(1'b1, 8'h03);
    sb_q.push_back(8'h20);
    btn_mode = 1'b1;
    rot_a = 1'b1;
    tick(16);
    btn_mode = 1'b0;
    rot_a = 1'b0;
    tick(30);
    drain();
    chk("simul_addr", {24'd0, addr}, 32'h20);

    // Reset during pending debounce
    press_mode(8'h40);
    press_mode(8'h00);
    for (int unsigned i = 0; i < 5; i++) step(1'b1, 8'(i + 1));
    rot_a = 1'b1;
    tick(5);
    rst = 1'b0;
    rot_a = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(50);
    chk("mid_rst_addr", {24'd0, addr}, 32'h00);

    // Button held through reset release is seen as a fresh press
    btn_mode = 1'b1;
    rst = 1'b0;
    tick(5);
    sb_q.push_back(8'h20);
    rst = 1'b1;
    tick(20);
    btn_mode = 1'b0;
    tick(20);
    drain();
    chk("held_rst_addr", {24'd0, addr}, 32'h20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
